// File: rtl/delay_line_sched_pkg.sv
// Shared helpers for the delay-line scheduler: requester-ID width.
// No logic of its own; consumers build their stage record from id_w().
package delay_sched_pkg;

  function automatic int id_w(input int n);
    return (n > 1 && $clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_line_sched_if.sv
// Requester/result bundle of delay_line_sched; 'slave' is the scheduler side.
// No flow control beyond the grant: results are never stalled.
interface delay_line_sched_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = delay_sched_pkg::id_w(NUM_REQ);

  logic [NUM_REQ-1:0]       i_req;
  logic [NUM_REQ*WIDTH-1:0] i_data;
  logic                     i_flush;
  logic [NUM_REQ-1:0]       o_gnt;
  logic                     o_ready;
  logic [WIDTH-1:0]         o_data;
  logic [ID_W-1:0]          o_id;
  logic                     o_valid;
  logic                     o_busy;

  modport master (
    output i_req, i_data, i_flush,
    input  o_gnt, o_ready, o_data, o_id, o_valid, o_busy
  );

  modport slave (
    input  i_req, i_data, i_flush,
    output o_gnt, o_ready, o_data, o_id, o_valid, o_busy
  );
endinterface

// File: rtl/delay_line_sched_pipe.sv
// LATENCY-stage shift of {valid, id, data}; one word per edge, clr empties all stages.
// Latency LATENCY cycles, no stall and no backpressure.
module delay_pipe #(
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [ID_W-1:0]  in_id,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [ID_W-1:0]  out_id,
  output logic [WIDTH-1:0] out_dat,
  output logic             busy
);
  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t stage_q [LATENCY];
  stage_t stage_d [LATENCY];

  // Idle launches carry zero id/data so an empty stage is all-zero.
  always_comb begin
    stage_d[0].valid = in_vld;
    stage_d[0].id    = in_vld ? in_id  : '0;
    stage_d[0].data  = in_vld ? in_dat : '0;
    for (int k = 1; k < LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < LATENCY; k++) begin
      if (clr) begin
        stage_q[k] <= '0;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | stage_q[k].valid;
    end
  end

  assign out_vld = stage_q[LATENCY-1].valid;
  assign out_id  = stage_q[LATENCY-1].id;
  assign out_dat = stage_q[LATENCY-1].data;
endmodule

// File: rtl/delay_line_sched.sv
// Round-robin grant of NUM_REQ requesters into a shared LATENCY-stage delay pipe.
// Result LATENCY cycles after grant; no backpressure, grants held off during warm-up/flush.
module delay_line_sched #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 3,
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst,
  delay_line_sched_if.slave bus
);
  import delay_sched_pkg::*;

  localparam int              ID_W      = id_w(NUM_REQ);
  localparam int              CNT_W     = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(LATENCY + 1);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   warm_q, warm_d;
  logic               ready, grant_en, gnt_any;
  logic [NUM_REQ-1:0] gnt;
  int                 win_i, nxt_i;
  logic [ID_W-1:0]    win;
  logic [WIDTH-1:0]   win_dat;
  logic               pipe_vld, pipe_busy;
  logic [ID_W-1:0]    pipe_id;
  logic [WIDTH-1:0]   pipe_dat;

  assign ready    = !rst && (warm_q == '0);
  assign grant_en = ready && !bus.i_flush;

  // Scan downward so the last hit is the first requester at or after the pointer.
  always_comb begin
    win_i   = 0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (grant_en && bus.i_req[(int'(ptr_q) + k) % NUM_REQ]) begin
        win_i   = (int'(ptr_q) + k) % NUM_REQ;
        gnt_any = 1'b1;
      end
    end
    gnt = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      gnt[r] = gnt_any && (win_i == r);
    end
    win     = win_i[ID_W-1:0];
    win_dat = bus.i_data[win_i*WIDTH +: WIDTH];
    nxt_i   = (win_i + 1) % NUM_REQ;
  end

  always_comb begin
    ptr_d  = gnt_any ? nxt_i[ID_W-1:0] : ptr_q;
    warm_d = (warm_q != '0) ? warm_q - 1'b1 : warm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      warm_q <= WARM_INIT;
    end else begin
      ptr_q  <= ptr_d;
      warm_q <= warm_d;
    end
  end

  delay_pipe #(
    .WIDTH   (WIDTH),
    .ID_W    (ID_W),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .clr     (rst | bus.i_flush),
    .in_vld  (gnt_any),
    .in_id   (win),
    .in_dat  (win_dat),
    .out_vld (pipe_vld),
    .out_id  (pipe_id),
    .out_dat (pipe_dat),
    .busy    (pipe_busy)
  );

  assign bus.o_gnt   = gnt;
  assign bus.o_ready = ready;
  assign bus.o_valid = pipe_vld && !rst;
  assign bus.o_id    = rst ? '0 : pipe_id;
  assign bus.o_data  = rst ? '0 : pipe_dat;
  assign bus.o_busy  = pipe_busy && !rst;
endmodule

// File: tb/tb_delay_line_sched.sv
// Directed bench for delay_line_sched: a cycle-indexed expected-output table
// plus hand-computed literal checks at the key points of each scenario.
module tb_delay_line_sched;
  localparam int W    = 8;
  localparam int L    = 3;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int RING = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_line_sched_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  delay_line_sched #(.WIDTH(W), .LATENCY(L), .NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: outputs are a table indexed by absolute cycle number.
  int               cyc     = 0;
  int               m_ptr   = 0;
  int               m_since = 0;
  bit               started = 1'b0;
  logic             exp_vld [RING];
  logic [IDW-1:0]   exp_id  [RING];
  logic [W-1:0]     exp_dat [RING];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int model_grant();
    if (rst || bus.i_flush || m_since < L + 1) return -1;
    return pick(bus.i_req, m_ptr);
  endfunction

  always begin
    int w;
    int cur;
    int slot;
    @(posedge clk);
    cur  = cyc;
    w    = model_grant();
    slot = (cur + L) % RING;
    exp_vld[slot] = 1'b0;
    exp_id[slot]  = '0;
    exp_dat[slot] = '0;
    if (rst || bus.i_flush) begin
      for (int j = 1; j <= L; j++) begin
        exp_vld[(cur + j) % RING] = 1'b0;
        exp_id[(cur + j) % RING]  = '0;
        exp_dat[(cur + j) % RING] = '0;
      end
    end
    if (rst) begin
      m_ptr   = 0;
      m_since = 0;
    end else begin
      if (m_since < L + 1) m_since++;
      if (w >= 0) begin
        exp_vld[slot] = 1'b1;
        exp_id[slot]  = w[IDW-1:0];
        exp_dat[slot] = bus.i_data[w*W +: W];
        m_ptr = (w + 1) % N;
      end
    end
    cyc     = cur + 1;
    started = 1'b1;
  end

  always begin
    int             w;
    int             s;
    logic [N-1:0]   eg;
    logic           ebusy;
    @(negedge clk);
    if (started) begin
      w  = model_grant();
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      s = cyc % RING;
      ebusy = 1'b0;
      for (int j = 0; j < L; j++) ebusy = ebusy | exp_vld[(cyc + j) % RING];
      chk("o_gnt",   32'(bus.o_gnt),   32'(eg));
      chk("o_ready", 32'(bus.o_ready), 32'(!rst && m_since >= L + 1));
      chk("o_valid", 32'(bus.o_valid), 32'(rst ? 1'b0 : exp_vld[s]));
      chk("o_id",    32'(bus.o_id),    32'(rst ? '0 : exp_id[s]));
      chk("o_data",  32'(bus.o_data),  32'(rst ? '0 : exp_dat[s]));
      chk("o_busy",  32'(bus.o_busy),  32'(!rst && ebusy));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < RING; i++) begin
      exp_vld[i] = 1'b0;
      exp_id[i]  = '0;
      exp_dat[i] = '0;
    end
    rst         = 1'b1;
    bus.i_req   = '0;
    bus.i_flush = 1'b0;
    bus.i_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    next();
    next();

    // Warm-up: four blocked cycles, then the first grant goes to req0.
    rst       = 1'b0;
    bus.i_req = 4'b1111;
    for (int i = 0; i < L + 1; i++) begin
      #4;
      chk("warm_gnt",   32'(bus.o_gnt),   32'h0);
      chk("warm_ready", 32'(bus.o_ready), 32'h0);
      next();
    end
    for (int k = 0; k < 8; k++) begin
      #4;
      chk("rr_gnt", 32'(bus.o_gnt), 32'(1 << (k % N)));
      if (k >= L) begin
        chk("rr_valid", 32'(bus.o_valid), 32'h1);
        chk("rr_id",    32'(bus.o_id),    32'((k - L) % N));
        chk("rr_data",  32'(bus.o_data),  32'(8'h10 + (k - L) % N));
      end
      next();
    end
    bus.i_req = '0;
    repeat (L + 1) next();

    // Single requester, pointer at 0.
    bus.i_data[2*W +: W] = 8'hA5;
    bus.i_req = 4'b0100;
    #4; chk("single_gnt", 32'(bus.o_gnt), 32'h4);
    next();
    bus.i_req = '0;
    #4; chk("single_t1_valid", 32'(bus.o_valid), 32'h0);
    next();
    #4; chk("single_t2_valid", 32'(bus.o_valid), 32'h0);
    next();
    #4;
    chk("single_t3_valid", 32'(bus.o_valid), 32'h1);
    chk("single_t3_id",    32'(bus.o_id),    32'h2);
    chk("single_t3_data",  32'(bus.o_data),  32'hA5);
    next();
    #4; chk("single_t4_valid", 32'(bus.o_valid), 32'h0);
    next();

    // Pointer at 3: req3, then req1/req3 alternate across the wrap.
    bus.i_req = 4'b1000;
    #4; chk("wrap_gnt0", 32'(bus.o_gnt), 32'h8);
    next();
    bus.i_req = 4'b1010;
    #4; chk("wrap_gnt1", 32'(bus.o_gnt), 32'h2);
    next();
    #4; chk("wrap_gnt2", 32'(bus.o_gnt), 32'h8);
    next();
    #4; chk("wrap_gnt3", 32'(bus.o_gnt), 32'h2);
    next();
    bus.i_req = '0;
    repeat (L + 1) next();

    // Flush with three words in flight; pointer at 2.
    bus.i_req = 4'b1111;
    #4; chk("fl_gnt0", 32'(bus.o_gnt), 32'h4);
    next();
    #4; chk("fl_gnt1", 32'(bus.o_gnt), 32'h8);
    next();
    #4; chk("fl_gnt2", 32'(bus.o_gnt), 32'h1);
    next();
    bus.i_flush = 1'b1;
    #4;
    chk("fl_cycle_gnt",   32'(bus.o_gnt),   32'h0);
    chk("fl_cycle_valid", 32'(bus.o_valid), 32'h1);
    chk("fl_cycle_id",    32'(bus.o_id),    32'h2);
    next();
    bus.i_flush = 1'b0;
    #4;
    chk("fl_after_busy",  32'(bus.o_busy),  32'h0);
    chk("fl_after_valid", 32'(bus.o_valid), 32'h0);
    chk("fl_after_gnt",   32'(bus.o_gnt),   32'h2);
    next();
    #4;
    chk("fl_after2_valid", 32'(bus.o_valid), 32'h0);
    chk("fl_after2_gnt",   32'(bus.o_gnt),   32'h4);
    next();

    // Reset with two words in flight and the pointer at 3.
    rst = 1'b1;
    #4;
    chk("rst_gnt",   32'(bus.o_gnt),   32'h0);
    chk("rst_ready", 32'(bus.o_ready), 32'h0);
    next();
    rst = 1'b0;
    for (int i = 0; i < L + 1; i++) begin
      #4;
      chk("rst_warm_gnt",   32'(bus.o_gnt),   32'h0);
      chk("rst_warm_valid", 32'(bus.o_valid), 32'h0);
      next();
    end
    #4; chk("rst_first_gnt", 32'(bus.o_gnt), 32'h1);
    next();
    bus.i_req = '0;
    repeat (L + 2) next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_line_sched.md
Name: delay_line_sched

Overview:
Round-robin scheduler that shares one fixed-latency delay pipeline between NUM_REQ requesters. Each cycle it grants at most one requester and launches that requester's word, tagged with the requester ID, into a LATENCY-stage shift pipeline. The ID-tagged result is presented at the pipeline output. Sits in front of the delay-line datapath: it owns arbitration, post-reset warm-up and flush sequencing.

Parameters:
WIDTH, 8, data word width in bits
LATENCY, 3, pipeline depth in stages (>= 1)
NUM_REQ, 4, number of requesters (>= 2)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
i_req  input  NUM_REQ  per-requester request; held until granted
i_data  input  NUM_REQ*WIDTH  per-requester data; requester r at bits [r*WIDTH +: WIDTH]
i_flush  input  1  synchronous pipeline flush
o_gnt  output  NUM_REQ  one-hot grant, combinational from i_req/state; data accepted in the cycle it is high
o_ready  output  1  warm-up complete; grants permitted
o_data  output  WIDTH  last-stage data
o_id  output  ID_W  last-stage requester ID, ID_W = max(1, $clog2(NUM_REQ))
o_valid  output  1  last-stage data valid
o_busy  output  1  any stage holds a valid word

Behaviour:
- Reset (rst high at an edge): all stage valid, data and ID bits cleared to 0; RR pointer = 0; warm-up counter = LATENCY+1. While rst is high: o_gnt=0, o_ready=0, o_valid=0, o_busy=0, o_data=0, o_id=0.
- Warm-up: after reset release, counter decrements by 1 per edge and saturates at 0. o_ready = (counter==0), so the first grant is possible LATENCY+1 cycles after rst falls. o_gnt is forced to 0 while o_ready=0.
- Arbitration: when o_ready=1 and i_flush=0, grant the first requester with i_req=1, searching upward from the pointer and wrapping from NUM_REQ-1 to 0. If no requester is asserted, o_gnt=0.
- Pointer: on a grant to requester w, pointer <= (w+1) mod NUM_REQ. With no grant, pointer holds.
- Launch: at the edge of a grant cycle, stage0 <= {valid=1, id=w, data=i_data[w]}. With no grant, stage0 <= {0,0,0}. Stage k <= stage k-1 every edge; there is no stall and no backpressure.
- Latency: a word granted in cycle t appears on o_valid/o_data/o_id in cycle t+LATENCY, for exactly one cycle. Back-to-back grants give back-to-back outputs.
- o_busy = OR of all stage valid bits.
- Flush: i_flush=1 sampled at an edge clears every stage (valid, data, ID) to 0. o_gnt=0 in the flush cycle. Pointer and warm-up counter are unchanged, and warm-up does not restart. In-flight words are dropped silently.
- Priority: rst over i_flush over grant.
- Requester protocol: a requester whose i_req drops before grant is simply skipped. i_data is don't-care while i_req=0.
- Reset mid-operation: all in-flight words are discarded, the pointer returns to 0 and warm-up restarts at LATENCY+1.

Decomposition:
- Package delay_sched_pkg:
  - ID width function id_w(n) = max(1, $clog2(n)).
  - Stage record typedef {valid, id, data}, parameterized by the widths via a localparam in the consumer.
- Sub-module delay_pipe: LATENCY-stage shift register of the stage record, with synchronous clear driven by rst|i_flush. Arbiter, pointer and warm-up logic stay in delay_line_sched.

Test Plan:
- Warm-up: rst for 2 cycles, then i_req=4'b1111 constant -> o_gnt=0 and o_ready=0 for exactly 4 cycles after rst falls; first grant to req0 in the 5th cycle.
- Single requester: req2 only, data 0xA5 -> o_gnt=4'b0100 in cycle t. o_valid=1, o_id=2, o_data=0xA5 in cycle t+3 only.
- Rotation/fairness: all four requesting continuously with data 0x10..0x13 -> grants 0,1,2,3,0,1... every cycle. Outputs carry IDs 0,1,2,3 on consecutive cycles starting LATENCY after the first grant.
- Pointer wrap with gaps: req3 granted, then only req1 and req3 requesting -> next grant req1, then req3, then req1 (pointer wraps 0 -> 1).
- Flush mid-flight: grant 3 words back-to-back, assert i_flush on the cycle after the third -> o_valid stays 0 thereafter. o_busy=0 the cycle after the flush edge. The next grant goes to the requester after the last winner.
- Reset mid-operation: rst pulse with 2 words in flight and the pointer at 3 -> no o_valid for those words, next grant waits LATENCY+1 cycles and goes to req0.
